// File: rtl/pool_window_packer_if.sv
// Activation beat stream into the packer plus the packed-window strobe toward Pooling.
// POOL_PACK_FRAME_EN adds act_last (upstream) and the sticky frame_err flag.
interface pool_window_packer_if #(
    parameter int unsigned NUM_POOLING = 8,
    parameter int unsigned NBEAT       = 4,
    parameter int unsigned IFM_BIT     = 8
);
    logic                                 act_valid;
    logic                                 act_ready;
    logic [NUM_POOLING*IFM_BIT-1:0]       act_data;
    logic                                 pool_in_valid;
    logic [NUM_POOLING*NBEAT*IFM_BIT-1:0] ACTIVATION;

`ifdef POOL_PACK_FRAME_EN
    logic act_last;
    logic frame_err;

    modport master (
        output act_valid, act_data, act_last,
        input  act_ready, pool_in_valid, ACTIVATION, frame_err
    );
    modport slave (
        input  act_valid, act_data, act_last,
        output act_ready, pool_in_valid, ACTIVATION, frame_err
    );
`else
    modport master (
        output act_valid, act_data,
        input  act_ready, pool_in_valid, ACTIVATION
    );
    modport slave (
        input  act_valid, act_data,
        output act_ready, pool_in_valid, ACTIVATION
    );
`endif
endinterface

// File: rtl/pool_window_packer.sv
// Gathers SIZE*SIZE window beats into the Pooling ACTIVATION bus and paces the in_valid strobe.
// Optional feature macro: POOL_PACK_FRAME_EN (act_last border windows, sticky frame_err).
module pool_window_packer #(
    parameter int unsigned BOTTLENECK = 32,
    parameter int unsigned SIZE       = 2,
    parameter int unsigned STRIDE     = 2,
    parameter int unsigned DELTA_X    = 4,
    parameter int unsigned OU         = 4,
    parameter int unsigned IN_CH      = 512,
    parameter int unsigned IFM_BIT    = 8
) (
    input logic                clk,
    input logic                rst,
    pool_window_packer_if.slave bus
);
    localparam int unsigned NUM_CYCLE   = BOTTLENECK / DELTA_X * OU * STRIDE;
    localparam int unsigned NUM_POOLING = IN_CH / NUM_CYCLE;
    localparam int unsigned NBEAT       = SIZE * SIZE;
    localparam int unsigned BeatW       = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int unsigned GapW        = (NUM_CYCLE > 1) ? $clog2(NUM_CYCLE) : 1;
    localparam logic [BeatW-1:0] LastBeat  = BeatW'(NBEAT - 1);
    localparam logic [GapW-1:0]  GapReload = GapW'(NUM_CYCLE - 1);

    typedef enum logic [0:0] {StFill, StWait} state_e;

    state_e                               state_q;
    logic [BeatW-1:0]                     beat_cnt_q;
    logic [GapW-1:0]                      gap_cnt_q;
    logic                                 pool_in_valid_q;
    logic [NUM_POOLING*NBEAT*IFM_BIT-1:0] act_q, act_d;
    logic                                 accept;
    logic                                 window_done;

    assign bus.act_ready     = (state_q == StFill) && !rst;
    assign accept            = bus.act_valid && bus.act_ready;
    assign bus.pool_in_valid = pool_in_valid_q;
    assign bus.ACTIVATION    = act_q;

`ifdef POOL_PACK_FRAME_EN
    logic frame_err_q;
    assign bus.frame_err = frame_err_q;
    assign window_done   = (beat_cnt_q == LastBeat) || bus.act_last;
`else
    assign window_done   = (beat_cnt_q == LastBeat);
`endif

    // Beat k of channel c lands in slot c*NBEAT+k; an early act_last zero-fills the tail slots.
    always_comb begin
        act_d = act_q;
        if (accept) begin
            for (int unsigned c = 0; c < NUM_POOLING; c++) begin
                for (int unsigned k = 0; k < NBEAT; k++) begin
                    if (BeatW'(k) == beat_cnt_q)
                        act_d[(c*NBEAT+k)*IFM_BIT +: IFM_BIT] = bus.act_data[c*IFM_BIT +: IFM_BIT];
`ifdef POOL_PACK_FRAME_EN
                    else if (bus.act_last && (BeatW'(k) > beat_cnt_q))
                        act_d[(c*NBEAT+k)*IFM_BIT +: IFM_BIT] = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StFill;
            beat_cnt_q      <= '0;
            gap_cnt_q       <= '0;
            pool_in_valid_q <= 1'b0;
            act_q           <= '0;
`ifdef POOL_PACK_FRAME_EN
            frame_err_q     <= 1'b0;
`endif
        end else begin
            act_q           <= act_d;
            pool_in_valid_q <= 1'b0;
            if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        if (window_done) begin
                            beat_cnt_q <= '0;
                            state_q    <= StWait;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
`ifdef POOL_PACK_FRAME_EN
                        if ((beat_cnt_q == LastBeat) && !bus.act_last) frame_err_q <= 1'b1;
`endif
                    end
                end
                StWait: begin
                    // Pulse cycle is already a FILL cycle so the next window can start at once.
                    if (gap_cnt_q == '0) begin
                        pool_in_valid_q <= 1'b1;
                        gap_cnt_q       <= GapReload;
                        state_q         <= StFill;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end
endmodule
